qed_i_cache: RTL
================

QED_I_CACHE -- requirements
Module: qed_i_cache

Interface
REQ-001 Parameter ICACHE_DEPTH, default 16, entries of original-instruction storage (power of two, >=2).
REQ-002 Parameter NOP, default 32'h15000000, ORBIS32 l.nop word driven when no instruction is issued.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ifu_qed_instruction  input  32  instruction word from fetch.
REQ-006 ifu_vld  input  1  ifu_qed_instruction valid this cycle.
REQ-007 IF_stall  input  1  pipeline stall; no instruction consumed while high.
REQ-008 exec_dup  input  1  request duplicate (replay) phase.
REQ-009 qic_qimux_instruction  output  32  instruction to the QED modify/mux stage.
REQ-010 vld_out  output  1  qic_qimux_instruction is a real instruction (not filler NOP).
REQ-011 num_orig_insts  output  $clog2(ICACHE_DEPTH)+1  originals captured.
REQ-012 num_dup_insts  output  $clog2(ICACHE_DEPTH)+1  duplicates replayed.
REQ-013 cache_full  output  1  num_orig_insts == ICACHE_DEPTH.
REQ-014 dup_done  output  1  replay complete (state DONE).

Function
REQ-015 FSM states SHALL be ORIG, DUP, DONE; encoded in a registered state variable.
REQ-016 ORIG->DUP SHALL occur at a clock edge where exec_dup=1, IF_stall=0 and num_orig_insts>0.
REQ-017 ORIG with exec_dup=1 and num_orig_insts==0 SHALL remain in ORIG (nothing to replay).
REQ-018 DUP->DONE SHALL occur at the edge on which the last replay is consumed (num_dup_insts becomes equal to num_orig_insts).
REQ-019 DONE->ORIG SHALL occur at an edge where exec_dup=0, clearing both counters and pointers in the same edge.
REQ-020 DUP with exec_dup deasserted SHALL continue replay (exec_dup sampled only in ORIG and DONE).
REQ-021 ORIG accept = ifu_vld & ~IF_stall & ~cache_full & ~exec_dup; on accept, entry wr_ptr <- ifu_qed_instruction, wr_ptr and num_orig_insts +1.
REQ-022 ORIG output SHALL be combinational: qic_qimux_instruction = ifu_qed_instruction and vld_out=1 when accept, else NOP and vld_out=0 (0-cycle latency).
REQ-023 cache_full in ORIG SHALL block capture; fetched instructions are dropped and NOP issued.
REQ-024 DUP output SHALL be entry rd_ptr with vld_out=1; consume = ~IF_stall; on consume rd_ptr and num_dup_insts +1.
REQ-025 DONE output SHALL be NOP, vld_out=0, dup_done=1.
REQ-026 During IF_stall=1 no pointer, counter or state SHALL change; output SHALL stay combinationally consistent with current state.
REQ-027 Pointers SHALL be $clog2(ICACHE_DEPTH) bits; counters one bit wider so count==ICACHE_DEPTH is representable without wrap.
REQ-028 Replay order SHALL equal capture order, entry 0 first; storage SHALL not be rewritten in DUP/DONE.
REQ-029 Storage array contents need not be reset; only counters, pointers and state are reset.

Reset
REQ-030 rst=1 at an edge SHALL force state ORIG, pointers 0, num_orig_insts=0, num_dup_insts=0, taking priority over every other event incl. mid-replay.
REQ-031 While in reset state outputs SHALL be: qic_qimux_instruction=NOP (if ifu_vld=0), vld_out=0, cache_full=0, dup_done=0.

Verification
REQ-032 Reset then 3 valid words A,B,C with IF_stall=0, exec_dup=0 -> each passed through same cycle, vld_out=1, num_orig_insts=3.
REQ-033 After REQ-032, exec_dup=1 -> next 3 cycles output A,B,C with vld_out=1, then NOP, vld_out=0, dup_done=1, num_dup_insts=3.
REQ-034 16 valid words then a 17th with ICACHE_DEPTH=16 -> cache_full=1 after 16th, 17th dropped, output NOP, vld_out=0, count stays 16.
REQ-035 IF_stall=1 for 2 cycles mid-replay after A issued -> B held on output both cycles, num_dup_insts unchanged, replay resumes with B.
REQ-036 exec_dup=1 with zero captured -> stays ORIG, output NOP, dup_done=0.
REQ-037 rst=1 during DUP after 1 of 3 replays -> next cycle state ORIG, counters 0, dup_done=0; exec_dup=0 in DONE -> ORIG with counters cleared.

Source files
------------

// File: rtl/qed_i_cache.sv
`default_nettype none
// qed_i_cache: records original instructions as they issue, then replays them
// in capture order so the QED duplicate stream can run. Filler slots issue NOP.
module qed_i_cache #(
  parameter int unsigned ICACHE_DEPTH = 16,
  parameter logic [31:0] NOP          = 32'h15000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     ifu_qed_instruction,
  input  logic                            ifu_vld,
  input  logic                            IF_stall,
  input  logic                            exec_dup,
  output logic [31:0]                     qic_qimux_instruction,
  output logic                            vld_out,
  output logic [$clog2(ICACHE_DEPTH):0]   num_orig_insts,
  output logic [$clog2(ICACHE_DEPTH):0]   num_dup_insts,
  output logic                            cache_full,
  output logic                            dup_done
);

  localparam int unsigned PW = $clog2(ICACHE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(ICACHE_DEPTH);

  typedef enum logic [1:0] {
    ST_ORIG = 2'd0,
    ST_DUP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    n_orig_q, n_orig_d;
  logic [CW-1:0]    n_dup_q, n_dup_d;
  logic [31:0]      mem_q [ICACHE_DEPTH];
  logic             wr_en;
  logic             full;
  logic             accept;
  logic [31:0]      out_instr;
  logic             out_vld;
  logic             out_done;

  assign full   = (n_orig_q == FULL_CNT);
  assign accept = (state_q == ST_ORIG) & ifu_vld & ~IF_stall & ~full & ~exec_dup;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    n_orig_d  = n_orig_q;
    n_dup_d   = n_dup_q;
    wr_en     = 1'b0;
    out_instr = NOP;
    out_vld   = 1'b0;
    out_done  = 1'b0;

    case (state_q)
      ST_ORIG: begin
        if (accept) begin
          out_instr = ifu_qed_instruction;
          out_vld   = 1'b1;
          wr_en     = 1'b1;
          wr_ptr_d  = wr_ptr_q + PW'(1);
          n_orig_d  = n_orig_q + CW'(1);
        end else if (exec_dup && !IF_stall && (n_orig_q != '0)) begin
          state_d = ST_DUP;
        end
      end
      ST_DUP: begin
        out_instr = mem_q[rd_ptr_q];
        out_vld   = 1'b1;
        if (!IF_stall) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          n_dup_d  = n_dup_q + CW'(1);
          if ((n_dup_q + CW'(1)) == n_orig_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        out_done = 1'b1;
        // Leaving DONE starts a fresh capture window from an empty cache.
        if (!IF_stall && !exec_dup) begin
          state_d  = ST_ORIG;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          n_orig_d = '0;
          n_dup_d  = '0;
        end
      end
      default: begin
        state_d = ST_ORIG;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ORIG;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      n_orig_q <= '0;
      n_dup_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      n_orig_q <= n_orig_d;
      n_dup_q  <= n_dup_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= ifu_qed_instruction;
    end
  end

  assign qic_qimux_instruction = out_instr;
  assign vld_out               = out_vld;
  assign num_orig_insts        = n_orig_q;
  assign num_dup_insts         = n_dup_q;
  assign cache_full            = full;
  assign dup_done              = out_done;

endmodule
`default_nettype wire
